ws2812_rx_decoder: RTL and testbench

Receive-side counterpart of the WS2812 LED driver. Samples a single-wire WS2812 data line, measures each high pulse to decode bits, and assembles GRB pixels. Detects the reset/latch gap that ends a frame. Used for driver loopback verification and for daisy-chained FPGA-to-FPGA pixel transport.

---
 rtl/ws2812_rx_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_ws2812_rx_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx_decoder.sv
// WS2812 receive decoder: synchronises the single-wire data line, measures each
// high pulse to recover bits, assembles GRB pixels and detects the latch gap.
// Optional macro WS_RX_PASSTHRU_EN builds a regenerated downstream line that
// swallows pixel 0 of each frame and forwards the rest.
module ws2812_rx_decoder #(
    parameter int CLK_CNT    = 125,
    parameter int BIT_THRESH = 60,
    parameter int MIN_HIGH   = 10,
    parameter int MAX_HIGH   = 110,
    parameter int RESET_GAP  = 5000
) (
    input  logic       i_clk,
    input  logic       rst_n,
    input  logic       i_din,
    output logic [7:0] o_green,
    output logic [7:0] o_red,
    output logic [7:0] o_blue,
    output logic       o_pix_valid,
    output logic [7:0] o_pix_index,
    output logic       o_frame_done,
    output logic       o_err,
    output logic       o_busy,
    output logic       o_dout
);

    // A valid high pulse must fit inside a bit period and the 0/1 threshold
    // must lie inside the accepted pulse window.
    if (MAX_HIGH >= CLK_CNT || BIT_THRESH <= MIN_HIGH || BIT_THRESH > MAX_HIGH
        || MAX_HIGH > 254 || RESET_GAP > 16383) begin : g_param_check
        $error("ws2812_rx_decoder: inconsistent timing parameters");
    end

    localparam logic [7:0]  THRESH_C = 8'(BIT_THRESH);
    localparam logic [7:0]  MIN_C    = 8'(MIN_HIGH);
    localparam logic [7:0]  MAX_C    = 8'(MAX_HIGH);
    localparam logic [13:0] GAP_C    = 14'(RESET_GAP);

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t      state_q;
    logic        sync1_q, din_s_q, din_prev_q;
    logic [7:0]  high_cnt_q;
    logic [13:0] low_cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [23:0] sh_q;
    logic [7:0]  pix_idx_q;
    logic [7:0]  green_q, red_q, blue_q, pix_index_q;
    logic        pix_valid_q, frame_done_q, err_q;

    logic        rise, fall, bit_val;
    logic [23:0] sh_d;

    assign rise    = din_s_q & ~din_prev_q;
    assign fall    = ~din_s_q & din_prev_q;
    assign bit_val = (high_cnt_q >= THRESH_C);
    assign sh_d    = {sh_q[22:0], bit_val};

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            din_s_q    <= 1'b0;
            din_prev_q <= 1'b0;
        end else begin
            sync1_q    <= i_din;
            din_s_q    <= sync1_q;
            din_prev_q <= din_s_q;
        end
    end

    // Decoder FSM: pulse measurement, bit assembly, pixel strobe and gap detection.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            sh_q         <= '0;
            pix_idx_q    <= '0;
            green_q      <= '0;
            red_q        <= '0;
            blue_q       <= '0;
            pix_index_q  <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                ST_SYNC: begin
                    // Wait for a full latch gap before trusting bit boundaries.
                    if (din_s_q) begin
                        low_cnt_q <= '0;
                    end else if (low_cnt_q >= GAP_C) begin
                        low_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        low_cnt_q <= low_cnt_q + 14'd1;
                    end
                end
                ST_IDLE: begin
                    if (rise) begin
                        state_q    <= ST_HIGH;
                        high_cnt_q <= 8'd1;
                        bit_cnt_q  <= '0;
                        sh_q       <= '0;
                        pix_idx_q  <= '0;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        if (high_cnt_q < MIN_C) begin
                            err_q     <= 1'b1;
                            low_cnt_q <= '0;
                            state_q   <= ST_SYNC;
                        end else begin
                            sh_q      <= sh_d;
                            low_cnt_q <= 14'd1;
                            state_q   <= ST_LOW;
                            if (bit_cnt_q == 5'd23) begin
                                green_q     <= sh_d[23:16];
                                red_q       <= sh_d[15:8];
                                blue_q      <= sh_d[7:0];
                                pix_valid_q <= 1'b1;
                                pix_index_q <= pix_idx_q;
                                bit_cnt_q   <= '0;
                                if (pix_idx_q != 8'hFF) begin
                                    pix_idx_q <= pix_idx_q + 8'd1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end else if (high_cnt_q > MAX_C) begin
                        err_q     <= 1'b1;
                        low_cnt_q <= '0;
                        state_q   <= ST_SYNC;
                    end else if (high_cnt_q != 8'hFF) begin
                        high_cnt_q <= high_cnt_q + 8'd1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_q    <= ST_HIGH;
                        high_cnt_q <= 8'd1;
                    end else if (low_cnt_q >= GAP_C) begin
                        // Latch gap: frame ends; leftover bits are a truncated pixel.
                        frame_done_q <= 1'b1;
                        err_q        <= (bit_cnt_q != 5'd0);
                        bit_cnt_q    <= '0;
                        sh_q         <= '0;
                        state_q      <= ST_IDLE;
                    end else if (low_cnt_q != 14'h3FFF) begin
                        low_cnt_q <= low_cnt_q + 14'd1;
                    end
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

    assign o_green      = green_q;
    assign o_red        = red_q;
    assign o_blue       = blue_q;
    assign o_pix_valid  = pix_valid_q;
    assign o_pix_index  = pix_index_q;
    assign o_frame_done = frame_done_q;
    assign o_err        = err_q;
    assign o_busy       = (state_q == ST_HIGH) || (state_q == ST_LOW);

`ifdef WS_RX_PASSTHRU_EN
    logic gate_q, dout_q;

    // Gate opens once pixel 0 is consumed, closes at frame end or loss of sync.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= 1'b0;
        end else if (frame_done_q || state_q == ST_SYNC) begin
            gate_q <= 1'b0;
        end else if (pix_valid_q) begin
            gate_q <= 1'b1;
        end
    end

    // Regenerated line: synchronised input delayed one more cycle, gated.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= din_s_q & gate_q;
        end
    end

    assign o_dout = dout_q;
`else
    assign o_dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: expected pixels are queued as they are
// sent and compared when the decoder strobes them.
module tb_ws2812_rx_decoder;

    logic       i_clk = 1'b0;
    logic       rst_n;
    logic       i_din;
    logic [7:0] o_green, o_red, o_blue, o_pix_index;
    logic       o_pix_valid, o_frame_done, o_err, o_busy, o_dout;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    int pix_cnt = 0, fd_cnt = 0, err_cnt = 0, both_cnt = 0, clash_cnt = 0;
    int dout_hi = 0, dout_rise = 0;
    logic dout_prev = 1'b0;

`ifdef WS_RX_PASSTHRU_EN
    localparam int PASS_RISES = 48;
`else
    localparam int PASS_RISES = 0;
`endif

    ws2812_rx_decoder dut (
        .i_clk        (i_clk),
        .rst_n        (rst_n),
        .i_din        (i_din),
        .o_green      (o_green),
        .o_red        (o_red),
        .o_blue       (o_blue),
        .o_pix_valid  (o_pix_valid),
        .o_pix_index  (o_pix_index),
        .o_frame_done (o_frame_done),
        .o_err        (o_err),
        .o_busy       (o_busy),
        .o_dout       (o_dout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-18s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboard on each strobe and tallies pulses.
    always @(negedge i_clk) begin
        if (o_pix_valid) begin
            pix_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pix", {o_green, o_red, o_blue}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pix_grb", {8'h00, o_green, o_red, o_blue}, {8'h00, e[23:0]});
                check("pix_index", {24'h0, o_pix_index}, {24'h0, e[31:24]});
            end
        end
        if (o_frame_done) fd_cnt++;
        if (o_err) err_cnt++;
        if (o_err && o_frame_done) both_cnt++;
        if (o_pix_valid && o_frame_done) clash_cnt++;
        if (o_dout) dout_hi++;
        if (o_dout && !dout_prev) dout_rise++;
        dout_prev = o_dout;
    end

    task automatic hold_low(input int n);
        i_din = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic send_bit(input logic b);
        i_din = 1'b1;
        repeat (b ? 80 : 40) @(negedge i_clk);
        i_din = 1'b0;
        repeat (b ? 45 : 85) @(negedge i_clk);
    endtask

    task automatic send_pixel(input logic [23:0] grb, input logic [7:0] idx, input bit expect_it);
        if (expect_it) exp_q.push_back({idx, grb});
        for (int i = 23; i >= 0; i--) send_bit(grb[i]);
    endtask

    initial begin
        int p0, f0, e0, b0, r0;
        logic [47:0] junk;

        // Reset state
        rst_n = 1'b0;
        i_din = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_colour", {8'h00, o_green, o_red, o_blue}, 32'h0);
        check("rst_index", {24'h0, o_pix_index}, 32'h0);
        check("rst_strobes", {28'h0, o_pix_valid, o_frame_done, o_err, o_busy}, 32'h0);
        check("rst_dout", {31'h0, o_dout}, 32'h0);
        rst_n = 1'b1;

        // Sync after reset, then a single pixel frame
        hold_low(5050);
        send_pixel(24'hA53C81, 8'd0, 1'b1);
        check("busy_in_frame", {31'h0, o_busy}, 32'h1);
        hold_low(5050);
        check("t1_pix_cnt", pix_cnt, 1);
        check("t1_frame_done", fd_cnt, 1);
        check("t1_no_err", err_cnt, 0);
        check("idle_not_busy", {31'h0, o_busy}, 32'h0);

        // Reset released in the middle of a bit stream: nothing decoded
        rst_n = 1'b0;
        i_din = 1'b1;
        repeat (20) @(negedge i_clk);
        rst_n = 1'b1;
        repeat (30) @(negedge i_clk);
        i_din = 1'b0;
        repeat (85) @(negedge i_clk);
        junk = {$urandom, $urandom};
        p0 = pix_cnt; f0 = fd_cnt; e0 = err_cnt;
        for (int i = 0; i < 48; i++) send_bit(junk[i]);
        hold_low(5050);
        check("mid_no_pix", pix_cnt - p0, 0);
        check("mid_no_fd", fd_cnt - f0, 0);
        check("mid_no_err", err_cnt - e0, 0);
        send_pixel(24'h5AC318, 8'd0, 1'b1);
        hold_low(5050);
        check("mid_then_pix", pix_cnt - p0, 1);
        check("mid_then_fd", fd_cnt - f0, 1);

        // Two-pixel frame, then a new frame restarting at index 0
        p0 = pix_cnt; f0 = fd_cnt;
        send_pixel(24'h00FF00, 8'd0, 1'b1);
        send_pixel(24'h123456, 8'd1, 1'b1);
        hold_low(5050);
        check("two_pix_cnt", pix_cnt - p0, 2);
        check("two_pix_fd", fd_cnt - f0, 1);
        send_pixel(24'hDEADBE, 8'd0, 1'b1);
        hold_low(5050);

        // Glitch pulse and overlong pulse
        p0 = pix_cnt; e0 = err_cnt;
        i_din = 1'b1;
        repeat (5) @(negedge i_clk);
        hold_low(10);
        check("glitch_err", err_cnt - e0, 1);
        check("glitch_sync", {31'h0, o_busy}, 32'h0);
        hold_low(5050);
        i_din = 1'b1;
        repeat (120) @(negedge i_clk);
        hold_low(5050);
        check("long_err", err_cnt - e0, 2);
        check("err_no_pix", pix_cnt - p0, 0);

        // Partial pixel: frame done and error together
        p0 = pix_cnt; f0 = fd_cnt; b0 = both_cnt;
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        hold_low(5050);
        check("partial_both", both_cnt - b0, 1);
        check("partial_fd", fd_cnt - f0, 1);
        check("partial_no_pix", pix_cnt - p0, 0);

        // Three-pixel frame for the regenerated line
        r0 = dout_rise;
        send_pixel(24'hF0F0F0, 8'd0, 1'b1);
        check("dout_quiet_pix0", dout_rise - r0, 0);
        send_pixel(24'h0F0F0F, 8'd1, 1'b1);
        send_pixel(24'h3355AA, 8'd2, 1'b1);
        hold_low(5050);
        check("dout_rises", dout_rise - r0, PASS_RISES);

        // Global invariants
        check("queue_empty", exp_q.size(), 0);
        check("pix_fd_clash", clash_cnt, 0);
`ifndef WS_RX_PASSTHRU_EN
        check("dout_const0", dout_hi, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
